// File: rtl/counter_arbiter_if.sv
// Request/response bundle between two counter-job requesters and counter_arbiter.
// master = requester/counter side, slave = arbiter side.
interface counter_arbiter_if;
  logic        req0;
  logic        req1;
  logic [1:0]  mode0;
  logic [1:0]  mode1;
  logic [31:0] load0;
  logic [31:0] load1;
  logic [15:0] len0;
  logic [15:0] len1;
  logic        ack0;
  logic        ack1;
  logic        busy;
  logic        gnt;
  logic        enable;
  logic [1:0]  modo;
  logic [31:0] para;

  modport master (
    output req0, req1, mode0, mode1, load0, load1, len0, len1,
    input  ack0, ack1, busy, gnt, enable, modo, para
  );

  modport slave (
    input  req0, req1, mode0, mode1, load0, load1, len0, len1,
    output ack0, ack1, busy, gnt, enable, modo, para
  );
endinterface

// File: rtl/counter_arbiter.sv
// Two-requester arbiter driving an external up/down counter through IDLE/LOAD/RUN/DONE jobs.
// Define COUNTER_ARBITER_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module counter_arbiter (
  input  logic              clk,
  input  logic              reset,
  counter_arbiter_if.slave  bus
);

  localparam logic [1:0] MODE_HOLD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t      state_reg;
  logic [1:0]  mode_reg;
  logic [15:0] len_reg;
  logic [15:0] cnt_reg;
  logic        enable_reg;
  logic [1:0]  modo_reg;
  logic [31:0] para_reg;
  logic        ack0_reg;
  logic        ack1_reg;
  logic        busy_reg;
  logic        gnt_reg;

  logic [1:0]  req_vec;
  logic [1:0]  mode_arr [2];
  logic [31:0] load_arr [2];
  logic [15:0] len_arr  [2];
  logic        win;

  assign req_vec     = {bus.req1, bus.req0};
  assign mode_arr[0] = bus.mode0;
  assign mode_arr[1] = bus.mode1;
  assign load_arr[0] = bus.load0;
  assign load_arr[1] = bus.load1;
  assign len_arr[0]  = bus.len0;
  assign len_arr[1]  = bus.len1;

`ifdef COUNTER_ARBITER_RR_EN
  // Pointer names the requester favoured on a tie: the one not granted last.
  logic rr_ptr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= 1'b0;
    end else if (state_reg == IDLE && req_vec != 2'b00) begin
      rr_ptr_reg <= ~win;
    end
  end

  always_comb begin
    win = 1'b0;
    if (req_vec == 2'b11) begin
      win = rr_ptr_reg;
    end else begin
      win = req_vec[1];
    end
  end
`else
  always_comb begin
    win = 1'b0;
    if (!req_vec[0]) begin
      win = 1'b1;
    end
  end
`endif

  // All outputs are registered and updated together with the state so they
  // always describe the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      mode_reg   <= 2'b00;
      len_reg    <= 16'd0;
      cnt_reg    <= 16'd0;
      enable_reg <= 1'b0;
      modo_reg   <= MODE_HOLD;
      para_reg   <= 32'd0;
      ack0_reg   <= 1'b0;
      ack1_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      gnt_reg    <= 1'b0;
    end else begin
      ack0_reg <= 1'b0;
      ack1_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          enable_reg <= 1'b0;
          modo_reg   <= MODE_HOLD;
          busy_reg   <= 1'b0;
          if (req_vec != 2'b00) begin
            gnt_reg    <= win;
            mode_reg   <= mode_arr[win];
            len_reg    <= len_arr[win];
            para_reg   <= load_arr[win];
            enable_reg <= 1'b1;
            busy_reg   <= 1'b1;
            state_reg  <= LOAD;
          end
        end

        LOAD: begin
          if (len_reg == 16'd0 || mode_reg == MODE_HOLD) begin
            enable_reg <= 1'b0;
            modo_reg   <= MODE_HOLD;
            ack0_reg   <= ~gnt_reg;
            ack1_reg   <= gnt_reg;
            state_reg  <= DONE;
          end else begin
            enable_reg <= 1'b1;
            modo_reg   <= mode_reg;
            cnt_reg    <= len_reg;
            state_reg  <= RUN;
          end
        end

        RUN: begin
          // cnt_reg holds the RUN cycles remaining including the current one.
          if (cnt_reg == 16'd1) begin
            cnt_reg    <= 16'd0;
            enable_reg <= 1'b0;
            modo_reg   <= MODE_HOLD;
            ack0_reg   <= ~gnt_reg;
            ack1_reg   <= gnt_reg;
            state_reg  <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end

        DONE: begin
          enable_reg <= 1'b0;
          modo_reg   <= MODE_HOLD;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.enable = enable_reg;
  assign bus.modo   = modo_reg;
  assign bus.para   = para_reg;
  assign bus.ack0   = ack0_reg;
  assign bus.ack1   = ack1_reg;
  assign bus.busy   = busy_reg;
  assign bus.gnt    = gnt_reg;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: a per-cycle expectation queue is filled when
// each job is issued and drained one entry per clock while comparing the outputs.
module tb_counter_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  counter_arbiter_if bus ();

  counter_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic        enable;
    logic [1:0]  modo;
    logic [31:0] para;
    logic        ack0;
    logic        ack1;
    logic        gnt;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic push_rec(input logic b, input logic en, input logic [1:0] m,
                          input logic [31:0] p, input logic a0, input logic a1,
                          input logic g);
    exp_t e;
    e.busy = b; e.enable = en; e.modo = m; e.para = p;
    e.ack0 = a0; e.ack1 = a1; e.gnt = g;
    sb.push_back(e);
  endtask

  // Expected outputs for a whole job: LOAD, len RUN cycles (unless load-only), DONE.
  task automatic push_job(input logic g, input logic [1:0] m, input logic [31:0] ld,
                          input logic [15:0] ln);
    $display("job gnt=%0d mode=%0d load=%0d len=%0d", g, m, ld, ln);
    push_rec(1'b1, 1'b1, 2'b11, ld, 1'b0, 1'b0, g);
    if (ln != 16'd0 && m != 2'b11) begin
      for (int i = 0; i < int'(ln); i++) push_rec(1'b1, 1'b1, m, ld, 1'b0, 1'b0, g);
    end
    push_rec(1'b1, 1'b0, 2'b11, ld, ~g, g, g);
  endtask

  task automatic push_idle(input logic [31:0] p, input logic g);
    push_rec(1'b0, 1'b0, 2'b11, p, 1'b0, 1'b0, g);
  endtask

  task automatic cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL scoreboard_empty cycle=%0d observed=0 expected=1", cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("busy",   32'(bus.busy),   32'(e.busy));
        chk("enable", 32'(bus.enable), 32'(e.enable));
        chk("modo",   32'(bus.modo),   32'(e.modo));
        chk("para",   bus.para,        e.para);
        chk("ack0",   32'(bus.ack0),   32'(e.ack0));
        chk("ack1",   32'(bus.ack1),   32'(e.ack1));
        chk("gnt",    32'(bus.gnt),    32'(e.gnt));
      end
    end
  endtask

  initial begin
    logic g;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.mode0 = 2'b00; bus.mode1 = 2'b00;
    bus.load0 = 32'd0; bus.load1 = 32'd0;
    bus.len0 = 16'd0; bus.len1 = 16'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_idle(32'd0, 1'b0);
    cycles(1);

    // Basic up-count job; load0 changes mid-job and must be ignored.
    bus.req0 = 1'b1; bus.mode0 = 2'b00; bus.load0 = 32'd700; bus.len0 = 16'd4;
    push_job(1'b0, 2'b00, 32'd700, 16'd4);
    push_idle(32'd700, 1'b0);
    cycles(1);
    bus.req0 = 1'b0; bus.load0 = 32'd900; bus.mode0 = 2'b01; bus.len0 = 16'd2;
    cycles(6);

    // Next job picks up the new load value.
    bus.req0 = 1'b1;
    push_job(1'b0, 2'b01, 32'd900, 16'd2);
    push_idle(32'd900, 1'b0);
    cycles(1);
    bus.req0 = 1'b0;
    cycles(4);

    // Load-only job from requester 1.
    bus.req1 = 1'b1; bus.mode1 = 2'b11; bus.load1 = 32'd5000000; bus.len1 = 16'd9;
    push_job(1'b1, 2'b11, 32'd5000000, 16'd9);
    push_idle(32'd5000000, 1'b1);
    cycles(1);
    bus.req1 = 1'b0;
    cycles(2);

    // Zero length with down-by-3 mode: no RUN cycles.
    bus.req0 = 1'b1; bus.mode0 = 2'b10; bus.load0 = 32'd123; bus.len0 = 16'd0;
    push_job(1'b0, 2'b10, 32'd123, 16'd0);
    push_idle(32'd123, 1'b0);
    cycles(1);
    bus.req0 = 1'b0;
    cycles(2);

    // Down-by-3 counting.
    bus.req0 = 1'b1; bus.mode0 = 2'b10; bus.load0 = 32'd42; bus.len0 = 16'd3;
    push_job(1'b0, 2'b10, 32'd42, 16'd3);
    push_idle(32'd42, 1'b0);
    cycles(1);
    bus.req0 = 1'b0;
    cycles(5);

    // Reset during the 3rd RUN cycle of a len=10 job: no ack afterwards.
    bus.req0 = 1'b1; bus.mode0 = 2'b00; bus.load0 = 32'd555; bus.len0 = 16'd10;
    $display("job gnt=0 mode=0 load=555 len=10 (reset mid-run)");
    push_rec(1'b1, 1'b1, 2'b11, 32'd555, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push_rec(1'b1, 1'b1, 2'b00, 32'd555, 1'b0, 1'b0, 1'b0);
    cycles(1);
    bus.req0 = 1'b0;
    cycles(3);
    reset = 1'b1;
    push_idle(32'd0, 1'b0);
    cycles(1);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) push_idle(32'd0, 1'b0);
    cycles(12);

    // Both requesters held high with load-only jobs.
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.mode0 = 2'b11; bus.mode1 = 2'b11;
    bus.load0 = 32'd11; bus.load1 = 32'd22;
    bus.len0 = 16'd0; bus.len1 = 16'd0;
    for (int i = 0; i < 4; i++) begin
`ifdef COUNTER_ARBITER_RR_EN
      g = i[0];
`else
      g = 1'b0;
`endif
      push_job(g, 2'b11, g ? 32'd22 : 32'd11, 16'd0);
      push_idle(g ? 32'd22 : 32'd11, g);
      cycles(3);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
`ifdef COUNTER_ARBITER_RR_EN
    g = 1'b1;
`else
    g = 1'b0;
`endif
    push_idle(g ? 32'd22 : 32'd11, g);
    push_idle(g ? 32'd22 : 32'd11, g);
    cycles(2);

    // Maximum length: 65535 RUN cycles without wrap.
    bus.req0 = 1'b1; bus.mode0 = 2'b01; bus.load0 = 32'hDEADBEEF; bus.len0 = 16'hFFFF;
    push_job(1'b0, 2'b01, 32'hDEADBEEF, 16'hFFFF);
    push_idle(32'hDEADBEEF, 1'b0);
    cycles(1);
    bus.req0 = 1'b0;
    cycles(65537);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have ports req0 and req1, input, 1 bit each: job request from requester 0 and requester 1.
REQ-004 The block SHALL have ports mode0 and mode1, input, 2 bits each: requested counter mode (00 up by 1, 01 down by 1, 10 down by 3, 11 load only).
REQ-005 The block SHALL have ports load0 and load1, input, 32 bits each: value parallel-loaded into the counter at job start.
REQ-006 The block SHALL have ports len0 and len1, input, 16 bits each: number of counting cycles after the load.
REQ-007 The block SHALL have ports ack0 and ack1, output, 1 bit each: one-cycle job-complete pulse to the owning requester.
REQ-008 The block SHALL have port busy, output, 1 bit: a job is in progress (any state other than IDLE).
REQ-009 The block SHALL have port gnt, output, 1 bit: index of the requester owning the current job; value held after the job ends.
REQ-010 The block SHALL have port enable, output, 1 bit: counter change enable.
REQ-011 The block SHALL have port modo, output, 2 bits: counter mode (00 up1, 01 down1, 10 down3, 11 parallel load/hold).
REQ-012 The block SHALL have port para, output, 32 bits: counter parallel-load value.

Function
REQ-013 FSM SHALL have four states: IDLE, LOAD, RUN, DONE.
REQ-014 In IDLE the block SHALL drive enable=0 and modo=11, and SHALL hold para.
REQ-015 In IDLE, on an edge with req0 or req1 high, the block SHALL arbitrate, latch the winner's mode, load and len, set gnt, and go to LOAD.
REQ-016 In LOAD, lasting exactly 1 cycle, the block SHALL drive enable=1, modo=11 and para=latched load.
REQ-017 From LOAD the block SHALL go to DONE if latched len=0 or latched mode=11, and to RUN otherwise.
REQ-018 In RUN the block SHALL drive enable=1 and modo=latched mode for exactly len consecutive cycles, using a 16-bit down-counter, then go to DONE.
REQ-019 In DONE, lasting 1 cycle, the block SHALL drive enable=0 and modo=11, assert ack[gnt] only, and then go to IDLE.
REQ-020 Job latency SHALL be: LOAD in the cycle after the grant edge; ack in cycle 2+len after the grant edge (cycle 2 for a load-only job).
REQ-021 req, mode, load and len SHALL be sampled only at the grant edge; changes during a job SHALL be ignored.
REQ-022 A req still high in the cycle after DONE SHALL be treated as a new job; there SHALL be no idle gap requirement beyond the IDLE cycle itself.
REQ-023 len=16'hFFFF SHALL give 65535 RUN cycles with no counter wrap.
REQ-024 The block SHALL perform no arithmetic on para; counter overflow is the counter's concern.

Reset
REQ-025 On reset high at any clock edge, including mid-job, the block SHALL go to IDLE with enable=0, modo=11, para=0, ack0=ack1=0, busy=0, gnt=0, the RUN counter cleared, and the round-robin pointer favouring requester 0.
REQ-026 An interrupted job SHALL receive no ack.

Configuration
REQ-027 With macro COUNTER_ARBITER_RR_EN defined, arbitration SHALL be round-robin: the pointer favours the requester not granted last, and on simultaneous requests the favoured requester wins.
REQ-028 Without COUNTER_ARBITER_RR_EN, arbitration SHALL be fixed priority with req0 always winning, and no pointer register SHALL exist.

Verification
REQ-029 Reset, then req0=1, mode0=00, load0=700, len0=4 -> LOAD with para=700 and modo=11; 4 RUN cycles with modo=00; ack0 pulse at cycle 6; busy high for 6 cycles.
REQ-030 req1=1, mode1=11, load1=5000000, len1=9 -> LOAD, then DONE; ack1 at cycle 2; no RUN cycles.
REQ-031 req0 and req1 held high, with COUNTER_ARBITER_RR_EN -> grants alternate 0,1,0,1; without it -> only gnt=0 is ever granted.
REQ-032 reset asserted in the 3rd RUN cycle of a len=10 job -> next cycle IDLE, enable=0, modo=11, para=0, no ack.
REQ-033 len0=0, mode0=10 -> no RUN cycles; ack0 at cycle 2.
REQ-034 load0 changed mid-job from 700 to 900 -> para stays 700; the next job loads the newly sampled value.
